goalie_stepper_ctrl: RTL

GOALIE_STEPPER_CTRL -- requirements
Module: goalie_stepper_ctrl

---
 rtl/goalie_stepper_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/goalie_stepper_ctrl.sv
// goalie_stepper_ctrl: homing and positioning controller for a 4-phase goalie stepper
module goalie_stepper_ctrl #(
    parameter int          STEP_DIV  = 100000,
    parameter int          DB_CYCLES = 1000,
    parameter logic [15:0] MAX_POS   = 16'd400,
    parameter logic [15:0] HOME_MAX  = 16'd600
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] target_pos,
    input  logic        target_valid,
    input  logic        limit_switch,
    output logic [3:0]  phases,
    output logic [15:0] cur_pos,
    output logic        busy,
    output logic        homed,
    output logic        fault
);
    localparam int DW = $clog2(STEP_DIV + 1);
    localparam int BW = $clog2(DB_CYCLES + 1);
    typedef enum logic [1:0] {HOME_SEEK, IDLE, MOVE, FAULT} state_t;
    state_t        state, state_n;
    logic          sync1, sync2, lim_db;
    logic [BW-1:0] db_cnt;
    logic [DW-1:0] div;
    logic          tick, homed_n;
    logic [1:0]    idx, idx_n;
    logic [15:0]   pos_n, tgt, tgt_n, home_cnt, home_cnt_n, clamp;

    assign tick   = div == DW'(STEP_DIV - 1);
    assign clamp  = target_pos > MAX_POS ? MAX_POS : target_pos;
    assign busy   = state == HOME_SEEK || state == MOVE;
    assign fault  = state == FAULT;
    assign phases = fault ? 4'b0000 : idx == 2'd0 ? 4'b1100 : idx == 2'd1 ? 4'b0110 :
                    idx == 2'd2 ? 4'b0011 : 4'b1001;

    // synchronise the raw switch, then let lim_db follow only after a stable run of the new level
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            lim_db <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= limit_switch;
            sync2 <= sync1;
            if (sync2 == lim_db)
                db_cnt <= '0;
            else if (db_cnt == BW'(DB_CYCLES - 1)) begin
                lim_db <= sync2;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end

    // step-rate divider, restarted whenever the state changes so every state gets full step spacing
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) div <= '0;
        else         div <= (state_n != state || tick) ? '0 : div + 1'b1;

    // state and motion registers
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state    <= HOME_SEEK;
            idx      <= 2'd0;
            cur_pos  <= 16'd0;
            tgt      <= 16'd0;
            home_cnt <= 16'd0;
            homed    <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cur_pos  <= pos_n;
            tgt      <= tgt_n;
            home_cnt <= home_cnt_n;
            homed    <= homed_n;
        end

    // next-state and stepping decisions; a step in MOVE always uses the tgt held before this edge
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        pos_n      = cur_pos;
        tgt_n      = tgt;
        home_cnt_n = home_cnt;
        homed_n    = homed;
        case (state)
            HOME_SEEK:
                if (lim_db) begin
                    pos_n   = 16'd0;
                    homed_n = 1'b1;
                    state_n = IDLE;
                end else if (home_cnt >= HOME_MAX)
                    state_n = FAULT;
                else if (tick) begin
                    idx_n      = idx - 2'd1;
                    home_cnt_n = home_cnt + 16'd1;
                end
            IDLE:
                if (target_valid) begin
                    tgt_n   = clamp;
                    state_n = clamp != cur_pos ? MOVE : IDLE;
                end
            MOVE: begin
                if (target_valid) tgt_n = clamp;
                if (cur_pos == tgt) begin
                    if (!target_valid) state_n = IDLE;
                end else if (tgt < cur_pos) begin
                    if (lim_db) begin
                        pos_n   = 16'd0;
                        tgt_n   = 16'd0;
                        state_n = IDLE;
                    end else if (tick) begin
                        idx_n = idx - 2'd1;
                        pos_n = cur_pos - 16'd1;
                    end
                end else if (tick) begin
                    if (cur_pos >= MAX_POS) begin
                        tgt_n   = cur_pos;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + 2'd1;
                        pos_n = cur_pos + 16'd1;
                    end
                end
            end
            default: state_n = FAULT;
        endcase
    end
endmodule
